regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a register bank among NUM_REQ requesters.
// Optional sticky lock feature is enabled by defining REGFILE_WR_ARB_LOCK_EN.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
`ifdef REGFILE_WR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [ID_W-1:0]           wr_grant_id
);

  logic [ADDR_W-1:0]  req_addr_a [NUM_REQ];
  logic [DATA_W-1:0]  req_data_a [NUM_REQ];

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [ID_W-1:0]    wr_id_q, wr_id_d;

  logic [NUM_REQ-1:0] eff_valid;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign req_data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef REGFILE_WR_ARB_LOCK_EN
  logic               locked_q, locked_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
  logic [NUM_REQ-1:0] lock_mask;

  // While locked, every requester except the lock owner is hidden from the scan.
  always_comb begin
    lock_mask = '1;
    if (locked_q) begin
      lock_mask = NUM_REQ'(1) << lock_id_q;
    end
  end

  assign eff_valid = req_valid & lock_mask;

  // Relocking on every accept reproduces set/clear semantics: while locked only
  // the owner can be accepted, so its req_lock bit decides whether the lock stays.
  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      locked_d  = req_lock[grant_id];
      lock_id_d = grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  assign eff_valid = req_valid;
`endif

  // Scan from ptr+1 upward with wrap; the first valid candidate wins.
  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int              sum;
      logic [ID_W-1:0] cand;
      sum = int'(ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = ID_W'(sum);
      if (!grant_found && eff_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign grant     = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
  assign req_ready = wr_stall ? '0 : grant;
  assign accept    = grant_found && !wr_stall;

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_id_d   = wr_id_q;
    if (accept) begin
      ptr_d     = grant_id;
      wr_addr_d = req_addr_a[grant_id];
      wr_data_d = req_data_a[grant_id];
      wr_id_d   = grant_id;
    end
  end

  // Reset leaves ptr at the last requester so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= ID_W'(NUM_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_id_q   <= wr_id_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_grant_id = wr_id_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (NUM_REQ=4, ADDR_W=5, DATA_W=32).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wr_stall;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [ID_W-1:0]           wr_grant_id;
`ifdef REGFILE_WR_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
`ifdef REGFILE_WR_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_grant_id(wr_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    wr_stall  = 1'b0;
`ifdef REGFILE_WR_ARB_LOCK_EN
    req_lock  = '0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_addr  = '0;
    req_data  = '0;
    apply_reset();
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++;
    if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    n_checks++;
    if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    n_checks++;
    if (wr_grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", wr_grant_id); end
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    $display("test_reset done");
    step();
  endtask

  task automatic test_single();
    set_req(2, 5'd3, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    n_checks++;
    if (wr_addr !== 5'd3) begin n_fail++; $display("FAIL single_wr_addr: got %0d expected 3", wr_addr); end
    n_checks++;
    if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
    n_checks++;
    if (wr_grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d expected 2", wr_grant_id); end
    $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
    step();
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_drop: got %b expected 0", wr_en); end
    step();
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(8 + i), 32'hA000_0000 + 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_ready;
      int         exp_prev;
      exp_ready = 4'b0001 << (k % 4);
      exp_prev  = (k + 3) % 4;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
      if (k > 0) begin
        n_checks++;
        if (wr_en !== 1'b1 || wr_grant_id !== 2'(exp_prev) || wr_addr !== 5'(8 + exp_prev))
          begin n_fail++; $display("FAIL rr_write[%0d]: got en=%b id=%0d addr=%0d expected en=1 id=%0d addr=%0d", k, wr_en, wr_grant_id, wr_addr, exp_prev, 8 + exp_prev); end
        $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_grant_id !== 2'd3 || wr_data !== 32'hA000_0003)
      begin n_fail++; $display("FAIL rr_last: got en=%b id=%0d data=%h expected en=1 id=3 data=a0000003", wr_en, wr_grant_id, wr_data); end
    $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
    step();
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b expected 0", wr_en); end
    step();
  endtask

  task automatic test_two_req_rotation();
    logic [3:0] exp_ready [3];
    logic [1:0] exp_id    [3];
    exp_ready[0] = 4'b1000; exp_ready[1] = 4'b0010; exp_ready[2] = 4'b1000;
    exp_id[0]    = 2'd1;    exp_id[1]    = 2'd3;    exp_id[2]    = 2'd1;
    set_req(1, 5'd17, 32'h1111_0001);
    set_req(3, 5'd19, 32'h3333_0003);
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rot_first_ready: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_ready[k]) begin n_fail++; $display("FAIL rot_ready[%0d]: got %b expected %b", k, req_ready, exp_ready[k]); end
      n_checks++;
      if (wr_en !== 1'b1 || wr_grant_id !== exp_id[k])
        begin n_fail++; $display("FAIL rot_write[%0d]: got en=%b id=%0d expected en=1 id=%0d", k, wr_en, wr_grant_id, exp_id[k]); end
      $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
      step();
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_grant_id !== 2'd3 || wr_addr !== 5'd19) begin n_fail++; $display("FAIL rot_last: got id=%0d addr=%0d expected id=3 addr=19", wr_grant_id, wr_addr); end
    step();
  endtask

  task automatic test_stall();
    set_req(0, 5'd4, 32'h0BAD_F00D);
    req_valid = 4'b0001;
    wr_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000 || wr_en !== 1'b0)
        begin n_fail++; $display("FAIL stall[%0d]: got ready=%b en=%b expected ready=0000 en=0", k, req_ready, wr_en); end
      step();
    end
    wr_stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001 || wr_en !== 1'b0)
      begin n_fail++; $display("FAIL stall_release: got ready=%b en=%b expected ready=0001 en=0", req_ready, wr_en); end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_grant_id !== 2'd0 || wr_data !== 32'h0BAD_F00D)
      begin n_fail++; $display("FAIL stall_write: got en=%b id=%0d data=%h expected en=1 id=0 data=0badf00d", wr_en, wr_grant_id, wr_data); end
    $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
    step();
  endtask

  task automatic test_async_reset();
    set_req(1, 5'd7, 32'h7777_7777);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    #1;
    n_checks++;
    if (wr_en !== 1'b1 || wr_grant_id !== 2'd1) begin n_fail++; $display("FAIL areset_pre: got en=%b id=%0d expected en=1 id=1", wr_en, wr_grant_id); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || wr_grant_id !== '0)
      begin n_fail++; $display("FAIL areset_clear: got en=%b addr=%0d data=%h id=%0d expected all 0", wr_en, wr_addr, wr_data, wr_grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_req(0, 5'd10, 32'h0000_00A0);
    set_req(2, 5'd12, 32'h0000_00A2);
    req_valid = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL areset_ptr: got ready=%b expected 0001", req_ready); end
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_grant_id !== 2'd0 || wr_addr !== 5'd10)
      begin n_fail++; $display("FAIL areset_write: got en=%b id=%0d addr=%0d expected en=1 id=0 addr=10", wr_en, wr_grant_id, wr_addr); end
    $display("write id=%0d addr=%0d data=%h", wr_grant_id, wr_addr, wr_data);
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_grant_id !== 2'd2 || wr_addr !== 5'd12) begin n_fail++; $display("FAIL areset_second: got id=%0d addr=%0d expected id=2 addr=12", wr_grant_id, wr_addr); end
    step();
  endtask

`ifdef REGFILE_WR_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    set_req(0, 5'd20, 32'h0000_0C00);
    set_req(1, 5'd21, 32'h0000_0C01);
    set_req(2, 5'd22, 32'h0000_0C02);
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_take: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b0101;
    req_lock  = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_block: got %b expected 0000", req_ready); end
    step();
    req_valid = 4'b0111;
    req_lock  = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_hold: got %b expected 0010", req_ready); end
    step();
    req_lock = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_release: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_after: got %b expected 0100", req_ready); end
    step();
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_two_req_rotation();
    test_stall();
    test_async_reset();
`ifdef REGFILE_WR_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
